// File: rtl/sr_bank_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sr_bank_driver : valid/ready driven S/R excitation for an ffSR register bank
// Optional readback/retry: define SR_BANK_DRIVER_READBACK_EN.   Rev 1.0
// ---------------------------------------------------------------------------
module sr_bank_driver #(
    parameter int WIDTH     = 4,
    parameter int MAX_RETRY = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_target,
    input  logic [WIDTH-1:0] y_in,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int CNT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [CNT_W-1:0] RETRY_LIMIT = CNT_W'(MAX_RETRY);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2,
        CHECK  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [CNT_W-1:0] retry_q, retry_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        s_d      = '0;
        r_d      = '0;
        retry_d  = retry_q;
        done_d   = 1'b0;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    target_d = req_target;
                    retry_d  = '0;
                    err_d    = 1'b0;
                    state_d  = DRIVE;
                end
            end
            DRIVE: begin
                // Set and reset masks are disjoint by construction, so s&r is never 1.
                s_d     = target_q & ~y_in;
                r_d     = ~target_q & y_in;
                state_d = SETTLE;
            end
            SETTLE: begin
`ifdef SR_BANK_DRIVER_READBACK_EN
                state_d = CHECK;
`else
                done_d  = 1'b1;
                state_d = IDLE;
`endif
            end
`ifdef SR_BANK_DRIVER_READBACK_EN
            CHECK: begin
                if (y_in == target_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (retry_q < RETRY_LIMIT) begin
                    retry_d = retry_q + 1'b1;
                    state_d = DRIVE;
                end else begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            target_q <= '0;
            s_q      <= '0;
            r_q      <= '0;
            retry_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            s_q      <= s_d;
            r_q      <= r_d;
            retry_q  <= retry_d;
            done_q   <= done_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
        end
    end

    assign s         = s_q;
    assign r         = r_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign req_ready = ready_q;
`ifdef SR_BANK_DRIVER_READBACK_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/sr_bank_driver.md
# sr_bank_driver

Excitation-side driver for a bank of `ffSR` flip-flops. Accepts a requested target word over a valid/ready handshake and computes per-bit S/R excitation from the bank's current outputs. Drives one excitation pulse, lets the bank settle, then optionally reads back and retries. Sits between control logic and an SR register bank, so no caller ever hand-builds S/R pairs or produces the illegal s=r=1 input.

## Interface
Parameters:
- `WIDTH`, 4, number of SR flip-flops driven.
- `MAX_RETRY`, 2, re-drive attempts after a failed readback; 0 means no retry.

Ports:
- `clock` input 1: single clock; all state updates on posedge.
- `reset` input 1: synchronous, active-high reset.
- `req_valid` input 1: target word offered.
- `req_ready` output 1: driver idle and able to accept.
- `req_target` input WIDTH: requested bank contents.
- `y_in` input WIDTH: readback from the bank's `y` outputs.
- `s` output WIDTH: set inputs to the bank, registered.
- `r` output WIDTH: reset inputs to the bank, registered.
- `busy` output 1: high in every non-IDLE state.
- `done` output 1: one-cycle completion pulse.
- `err` output 1: valid with `done`; high means readback never matched.

## Operation
- States: IDLE, DRIVE, SETTLE, CHECK. Retry counter width is clog2(MAX_RETRY+1).
- IDLE:
  - `req_ready`=1.
  - On `req_valid`: latch `req_target`, clear retry count and `err`, go to DRIVE.
- DRIVE:
  - Per bit, compare target bit t against `y_in` bit c.
  - t=1,c=0: s=1,r=0. t=0,c=1: s=0,r=1. t==c: s=0,r=0.
  - Go to SETTLE.
- SETTLE:
  - `s`,`r` return to all-zero (hold).
  - Go to CHECK.
- CHECK:
  - If `y_in`==target: pulse `done` with `err`=0, go to IDLE.
  - Else if retry count < MAX_RETRY: increment count, go to DRIVE.
  - Else: pulse `done` with `err`=1, go to IDLE.
- Invariant: for every bit, s&r is never 1 in any cycle, including after reset.
- `req_valid` while busy is ignored; no queuing. The held target is unaffected by `req_target` changes after acceptance.
- `err` holds its value after `done` until the next accepted request clears it.

## Timing
- Reset values: `s`=0, `r`=0, `done`=0, `err`=0, `busy`=0, `req_ready`=1, state IDLE, retry count 0.
- Reset mid-operation: at the next edge all of the above apply; any pending pulse is dropped and no `done` is issued.
- Edge sequence for a request:
  - Edge E0 accepts the request.
  - `s`/`r` are nonzero only during cycle E1..E2, exactly one cycle.
  - The bank captures them at E2.
  - CHECK samples `y_in` at E3.
- `done` is high in the cycle after E3, so latency from accept to `done` is 3 cycles with no retries.
- Each retry adds 3 cycles; worst-case latency is 3*(MAX_RETRY+1).
- `req_ready` returns high in the same cycle `done` is high, so back-to-back requests are accepted at that edge.
- A target equal to the current contents still traverses all states, with `s`=`r`=0 throughout and `done` after 3 cycles.

## Configuration
- Macro: `SR_BANK_DRIVER_READBACK_EN`.
- Defined: CHECK state and retry logic are present as described.
- Undefined:
  - CHECK is removed and SETTLE goes directly to IDLE, pulsing `done` with `err`=0.
  - Latency is 2 cycles.
  - `y_in` is used only for excitation in DRIVE.
  - `err` is tied to 0.

## Test plan
- Reset, bank 4'b0000, request 4'b1010 -> during the drive cycle `s`=4'b1010, `r`=4'b0000; `done`=1,`err`=0 three cycles after accept; bank reads 4'b1010.
- Bank 4'b1010, request 4'b0110 -> `s`=4'b0100, `r`=4'b1000 for one cycle; final bank 4'b0110; no bit ever has s=r=1.
- Bank stuck at 4'b0000 (readback forced) with MAX_RETRY=2, request 4'b0001 -> three drive pulses; `done`=1,`err`=1 at cycle 9 after accept; `err` clears on the next accept.
- `req_valid` held high with changing `req_target` while busy -> `req_ready`=0, only the first target is driven; back-to-back second request is accepted in the `done` cycle.
- `reset` asserted in SETTLE -> next cycle `s`=`r`=0, `busy`=0, `req_ready`=1, no `done` pulse.
- Macro undefined, request 4'b1111 from 4'b0000 -> `done` two cycles after accept, `err`=0.
